conv_frame_ctrl: RTL and testbench

Sequencer that feeds one N x N frame, in row-major order, through the streaming K_SIZE x K_SIZE convolutor. It accepts pixels on a valid/ready input stream and drives the convolutor's en/data_i. It tags every pixel with its row and column, suppresses results from windows that straddle the image border, and presents the (N-K_SIZE+1)^2 valid results on a valid/ready output stream. Backpressure is applied by stalling the convolutor's en, so no result is ever lost or duplicated.

---
 rtl/conv_frame_ctrl.sv | 167 ++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
// Sequences one N x N frame (row-major) through a streaming K_SIZE x K_SIZE
// convolutor with latency LAT. Tags every pixel with its coordinates so that
// results from windows that straddle the image border are dropped. The
// (N-K_SIZE+1)^2 valid results are presented on a valid/ready stream.
// Backpressure stalls the convolutor enable, so results are never lost or
// repeated.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle frame start (only honoured in IDLE)
//   busy, done      not-IDLE flag; one-cycle pulse after the last result handshake
//   s_valid/s_ready/s_data       input pixel stream
//   conv_en/conv_data            convolutor enable and data_i
//   conv_result                  convolutor data_o
//   m_valid/m_ready/m_data       result stream (m_data = conv_result)
//   m_last, m_row, m_col         last-result flag and output coordinates
module conv_frame_ctrl #(
  parameter int N          = 4,
  parameter int K_SIZE     = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LAT        = 1,
  localparam int OUT_N     = N - K_SIZE + 1,
  localparam int OW        = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  conv_en,
  output logic [DATA_WIDTH-1:0] conv_data,
  input  logic [DATA_WIDTH-1:0] conv_result,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [OW-1:0]         m_row,
  output logic [OW-1:0]         m_col
);

  localparam int CW = $clog2(N);
  // Row counter runs one past N-1 after the final pixel, so it needs the extra code.
  localparam int RW = $clog2(N + 1);
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT} state_t;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [OW-1:0] row;
    logic [OW-1:0] col;
  } tag_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [DW-1:0]   drain_cnt;
  tag_t [LAT-1:0]  tag_q;    // [0] newest, [LAT-1] aligned with conv_result
  tag_t [LAT-1:0]  tag_nxt;
  tag_t            tag_new;
  tag_t            head;
  logic            m_valid_q;
  logic            done_q;
  logic            adv;
  logic            last_pix;
  logic            drain_end;

  assign adv       = !m_valid_q || m_ready;
  assign last_pix  = (row == RW'(N - 1)) && (col == CW'(N - 1));
  assign drain_end = (int'(drain_cnt) == LAT - 2);
  assign head      = tag_q[LAT-1];

  // Tag for the pixel offered this cycle; bubbles (and any non-RUN state) carry an invalid tag.
  always_comb begin
    tag_new = '0;
    if (state == RUN) begin
      tag_new.vld  = (row >= RW'(K_SIZE - 1)) && (col >= CW'(K_SIZE - 1));
      tag_new.last = last_pix;
      if (tag_new.vld) begin
        tag_new.row = OW'(row - RW'(K_SIZE - 1));
        tag_new.col = OW'(col - CW'(K_SIZE - 1));
      end
    end
  end

  generate
    if (LAT == 1) begin : g_tag1
      assign tag_nxt = tag_new;
    end else begin : g_tagn
      assign tag_nxt = {tag_q[LAT-2:0], tag_new};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    conv_en   = 1'b0;
    conv_data = '0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        s_ready   = adv;
        conv_en   = s_valid && adv;
        conv_data = s_data;
        if (conv_en && last_pix) state_nxt = (LAT > 1) ? DRAIN : WAIT;
      end
      DRAIN: begin
        // Bubbles push the remaining real results out of the convolutor.
        conv_en = adv;
        if (adv && drain_end) state_nxt = WAIT;
      end
      WAIT: if (m_valid_q && m_ready && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
      tag_q     <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == WAIT) && m_valid_q && m_ready && m_last;
      if (state == IDLE && start) begin
        row       <= '0;
        col       <= '0;
        drain_cnt <= '0;
      end
      if (state == RUN && conv_en) begin
        if (col == CW'(N - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (state == DRAIN && conv_en) drain_cnt <= drain_cnt + DW'(1);
      // Tags move in lockstep with the convolutor registers. A push decides
      // m_valid outright (covers handshake + new result in one cycle).
      if (conv_en) begin
        tag_q     <= tag_nxt;
        m_valid_q <= tag_nxt[LAT-1].vld;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = conv_result;
  assign m_last  = m_valid_q && head.vld && head.last;
  assign m_row   = head.row;
  assign m_col   = head.col;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: DUT a (LAT=1) and DUT b (LAT=3), each
// driving a small all-ones 3x3 streaming convolutor model.
module tb_conv_frame_ctrl;
  localparam int N  = 4;
  localparam int K  = 3;
  localparam int DW = 16;
  localparam int OW = 1;
  localparam int HL = (K - 1) * N + K;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            l;
  } res_t;

  typedef struct {
    logic [DW-1:0] pix;
    bit            ev;
    logic [DW-1:0] ed;
    int            er;
    int            ec;
    bit            el;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, s_valid, m_ready, b_on;
  logic [DW-1:0] s_data;

  logic          a_busy, a_done, a_s_ready, a_conv_en, a_m_valid, a_m_last;
  logic [DW-1:0] a_conv_data, a_conv_result, a_m_data;
  logic [OW-1:0] a_m_row, a_m_col;
  logic          b_rst, b_start, b_s_valid;
  logic          b_busy, b_done, b_s_ready, b_conv_en, b_m_valid, b_m_last;
  logic [DW-1:0] b_conv_data, b_conv_result, b_m_data;
  logic [OW-1:0] b_m_row, b_m_col;

  assign b_rst     = rst || !b_on;
  assign b_start   = start && b_on;
  assign b_s_valid = s_valid && b_on;

  conv_frame_ctrl #(.N(N), .K_SIZE(K), .DATA_WIDTH(DW), .LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .conv_en(a_conv_en), .conv_data(a_conv_data), .conv_result(a_conv_result),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .m_row(a_m_row), .m_col(a_m_col));

  conv_frame_ctrl #(.N(N), .K_SIZE(K), .DATA_WIDTH(DW), .LAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .conv_en(b_conv_en), .conv_data(b_conv_data), .conv_result(b_conv_result),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .m_row(b_m_row), .m_col(b_m_col));

  // Convolutor models: history[0] is the newest pixel; the window ending at
  // pixel (r,c) covers offsets i*N+j.
  function automatic logic [DW-1:0] win_sum(input logic [HL-1:0][DW-1:0] h);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) s = s + h[i*N+j];
    return s;
  endfunction

  logic [HL-1:0][DW-1:0] a_hist = '0;
  logic [HL-1:0][DW-1:0] b_hist = '0;
  logic [DW-1:0]         a_res  = '0;
  logic [2:0][DW-1:0]    b_res  = '0;

  always @(posedge clk) begin
    if (a_conv_en) begin
      a_hist <= {a_hist[HL-2:0], a_conv_data};
      a_res  <= win_sum({a_hist[HL-2:0], a_conv_data});
    end
    if (b_conv_en) begin
      b_hist <= {b_hist[HL-2:0], b_conv_data};
      b_res  <= {b_res[1:0], win_sum({b_hist[HL-2:0], b_conv_data})};
    end
  end
  assign a_conv_result = a_res;
  assign b_conv_result = b_res[2];

  // Monitors sample on the falling edge; a handshake seen here completes on the next rising edge.
  res_t qa[$], qb[$];
  int   en_a = 0, en_b = 0, done_a = 0, done_b = 0, bub_b = 0, bub_nz_b = 0;

  always @(negedge clk) begin
    if (a_m_valid && m_ready) qa.push_back('{a_m_data, int'(a_m_row), int'(a_m_col), a_m_last});
    if (b_m_valid && m_ready) qb.push_back('{b_m_data, int'(b_m_row), int'(b_m_col), b_m_last});
    if (a_conv_en) en_a <= en_a + 1;
    if (b_conv_en) en_b <= en_b + 1;
    if (a_done) done_a <= done_a + 1;
    if (b_done) done_b <= done_b + 1;
    if (b_conv_en && !b_s_ready) begin
      bub_b <= bub_b + 1;
      if (b_conv_data != '0) bub_nz_b <= bub_nz_b + 1;
    end
  end

  int   checks = 0, failures = 0;
  res_t exp_r[4];
  vec_t tv[16];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_pix(input logic [DW-1:0] v);
    int n = 0;
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    while (!a_s_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_s_ready) timeout("s_ready wait");
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (done_a < target && n < 60) begin @(negedge clk); n++; end
    if (done_a < target) timeout("done wait");
    tick();
  endtask

  task automatic chk_res(input string nm, input res_t q[$], input int q0);
    chk({nm, " result count"}, q.size() - q0, 4);
    for (int i = 0; i < 4; i++)
      if (q0 + i < q.size()) begin
        chk($sformatf("%s data[%0d]", nm, i), q[q0+i].d, exp_r[i].d);
        chk($sformatf("%s row[%0d]", nm, i), q[q0+i].r, exp_r[i].r);
        chk($sformatf("%s col[%0d]", nm, i), q[q0+i].c, exp_r[i].c);
        chk($sformatf("%s last[%0d]", nm, i), q[q0+i].l, exp_r[i].l);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int q0, e0, d0, qb0, eb0, db0, bb0, bnz0, n;

    exp_r[0] = '{16'd54, 0, 0, 1'b0};
    exp_r[1] = '{16'd63, 0, 1, 1'b0};
    exp_r[2] = '{16'd90, 1, 0, 1'b0};
    exp_r[3] = '{16'd99, 1, 1, 1'b1};
    for (int k = 0; k < 16; k++) tv[k] = '{DW'(k + 1), 1'b0, '0, 0, 0, 1'b0};
    tv[10] = '{16'd11, 1'b1, 16'd54, 0, 0, 1'b0};
    tv[11] = '{16'd12, 1'b1, 16'd63, 0, 1, 1'b0};
    tv[14] = '{16'd15, 1'b1, 16'd90, 1, 0, 1'b0};
    tv[15] = '{16'd16, 1'b1, 16'd99, 1, 1, 1'b1};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; b_on = 1'b1;
    repeat (3) tick();
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    chk("reset s_ready", a_s_ready, 0);
    chk("reset conv_en", a_conv_en, 0);
    chk("reset m_valid", a_m_valid, 0);
    chk("reset m_last", a_m_last, 0);
    chk("reset m_row", a_m_row, 0);
    chk("reset m_col", a_m_col, 0);
    rst = 1'b0;
    tick();

    // Continuous stream, checked pixel by pixel; DUT b (LAT=3) sees the same stream.
    q0 = qa.size(); e0 = en_a; d0 = done_a;
    qb0 = qb.size(); eb0 = en_b; db0 = done_b; bb0 = bub_b; bnz0 = bub_nz_b;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      send_pix(tv[k].pix);
      chk($sformatf("s1 m_valid px%0d", k), a_m_valid, tv[k].ev);
      chk($sformatf("s1 m_last px%0d", k), a_m_last, tv[k].el);
      if (tv[k].ev) begin
        chk($sformatf("s1 m_data px%0d", k), a_m_data, tv[k].ed);
        chk($sformatf("s1 m_row px%0d", k), a_m_row, tv[k].er);
        chk($sformatf("s1 m_col px%0d", k), a_m_col, tv[k].ec);
      end
    end
    tick();
    chk("s1 done pulse", a_done, 1);
    chk("s1 busy after done", a_busy, 0);
    tick();
    chk("s1 done one cycle", a_done, 0);
    chk_res("s1", qa, q0);
    chk("s1 conv_en pulses", en_a - e0, 16);
    chk("s1 done count", done_a - d0, 1);
    n = 0;
    while (done_b == db0 && n < 40) begin @(negedge clk); n++; end
    if (done_b == db0) timeout("lat3 done wait");
    repeat (3) tick();
    chk_res("s4 lat3", qb, qb0);
    chk("s4 drain bubbles", bub_b - bb0, 2);
    chk("s4 bubble data nonzero", bub_nz_b - bnz0, 0);
    chk("s4 conv_en pulses", en_b - eb0, 18);
    chk("s4 done count", done_b - db0, 1);
    chk("s4 busy after done", b_busy, 0);
    b_on = 1'b0;
    tick();

    // Output backpressure on the first result.
    q0 = qa.size(); e0 = en_a; d0 = done_a;
    pulse_start();
    for (int k = 0; k < 11; k++) send_pix(tv[k].pix);
    m_ready = 1'b0; s_valid = 1'b1; s_data = tv[11].pix;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s2 stall m_valid", a_m_valid, 1);
      chk("s2 stall m_data", a_m_data, 54);
      chk("s2 stall m_row/col", {a_m_row, a_m_col}, 0);
      chk("s2 stall conv_en", a_conv_en, 0);
      chk("s2 stall s_ready", a_s_ready, 0);
      tick();
    end
    m_ready = 1'b1;
    for (int k = 11; k < 16; k++) send_pix(tv[k].pix);
    wait_done_a(d0 + 1);
    chk_res("s2", qa, q0);
    chk("s2 conv_en pulses", en_a - e0, 16);

    // Input bubbles: s_valid alternates with idle cycles.
    q0 = qa.size(); e0 = en_a; d0 = done_a;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      send_pix(tv[k].pix);
      tick();
    end
    wait_done_a(d0 + 1);
    chk_res("s3", qa, q0);
    chk("s3 conv_en pulses", en_a - e0, 16);
    chk("s3 done count", done_a - d0, 1);

    // Reset mid-frame, then a clean frame.
    pulse_start();
    for (int k = 0; k < 7; k++) send_pix(tv[k].pix);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s5 busy after reset", a_busy, 0);
    chk("s5 m_valid after reset", a_m_valid, 0);
    chk("s5 s_ready after reset", a_s_ready, 0);
    tick();
    q0 = qa.size(); e0 = en_a; d0 = done_a;
    pulse_start();
    for (int k = 0; k < 16; k++) send_pix(tv[k].pix);
    wait_done_a(d0 + 1);
    chk_res("s5", qa, q0);
    chk("s5 conv_en pulses", en_a - e0, 16);

    // s_valid in IDLE and start during RUN are both ignored.
    e0 = en_a;
    s_valid = 1'b1; s_data = 16'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s6 idle s_ready", a_s_ready, 0);
      chk("s6 idle conv_en", a_conv_en, 0);
      tick();
    end
    s_valid = 1'b0;
    chk("s6 idle pulses", en_a - e0, 0);
    q0 = qa.size(); e0 = en_a; d0 = done_a;
    pulse_start();
    for (int k = 0; k < 5; k++) send_pix(tv[k].pix);
    pulse_start();
    for (int k = 5; k < 16; k++) send_pix(tv[k].pix);
    wait_done_a(d0 + 1);
    chk_res("s6", qa, q0);
    chk("s6 conv_en pulses", en_a - e0, 16);
    chk("s6 done count", done_a - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
